// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// It runs the request-to-send sequence (clock held low, then start bit),
// presents data, parity and stop bits on device falling edges, checks the
// device ack, and holds rx_inhibit high so the scancode receiver ignores the
// bus while a transfer is in progress.
// Optional build macro PS2_TX_RETRY_EN: a NACK restarts the frame with the
// same byte up to two times before err is reported.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | tx_ready high, waiting for tx_valid
// INHIBIT   | ps2c pulled low for the inhibit time
// RELEASE   | start bit on ps2d, ps2c released on the next cycle
// SEND      | one bit per device falling edge: 8 data, parity, stop
// ACK       | sample ps2d on the ack falling edge
// WAITIDLE  | wait for both lines high, then report done
// FAIL      | release the lines and report err
module ps2_host_tx #(
    parameter int CLK_MHZ         = 50,
    parameter int INHIBIT_US      = 100,
    parameter int TIMEOUT_US      = 15000,
    parameter int DEBOUNCE_CYCLES = 64
) (
    input  logic       coreclk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       rx_inhibit,
    output logic       done,
    output logic       err
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_INHIBIT  = 3'd1;
    localparam logic [2:0] S_RELEASE  = 3'd2;
    localparam logic [2:0] S_SEND     = 3'd3;
    localparam logic [2:0] S_ACK      = 3'd4;
    localparam logic [2:0] S_WAITIDLE = 3'd5;
    localparam logic [2:0] S_FAIL     = 3'd6;

    localparam logic [19:0] INHIBIT_LOAD = 20'(INHIBIT_US * CLK_MHZ);
    localparam logic [19:0] TIMEOUT_LOAD = 20'(TIMEOUT_US * CLK_MHZ);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]     c_sync;
    logic [1:0]     d_sync;
    logic           c_filt;
    logic           d_filt;
    logic [DBW-1:0] c_cnt;
    logic [DBW-1:0] d_cnt;
    logic           fall;

    logic [2:0]     state;
    logic [19:0]    cnt;
    logic [3:0]     bitcnt;
    logic [9:0]     shift;
`ifdef PS2_TX_RETRY_EN
    logic [1:0]     retry;
`endif

    // Two-flop synchronizers for the raw pads; idle level is high.
    always_ff @(posedge coreclk) begin
        if (!rst) begin
            c_sync <= 2'b11;
            d_sync <= 2'b11;
        end else begin
            c_sync <= {c_sync[0], ps2c_in};
            d_sync <= {d_sync[0], ps2d_in};
        end
    end

    // Clock filter: adopt a new level after DEBOUNCE_CYCLES differing samples;
    // a 1->0 adoption produces the single-cycle fall event.
    always_ff @(posedge coreclk) begin
        if (!rst) begin
            c_filt <= 1'b1;
            c_cnt  <= '0;
            fall   <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (c_sync[1] == c_filt) begin
                c_cnt <= '0;
            end else if (c_cnt == DB_LAST) begin
                c_filt <= c_sync[1];
                c_cnt  <= '0;
                fall   <= c_filt;
            end else begin
                c_cnt <= c_cnt + 1'b1;
            end
        end
    end

    // Data filter, same rule as the clock filter.
    always_ff @(posedge coreclk) begin
        if (!rst) begin
            d_filt <= 1'b1;
            d_cnt  <= '0;
        end else if (d_sync[1] == d_filt) begin
            d_cnt <= '0;
        end else if (d_cnt == DB_LAST) begin
            d_filt <= d_sync[1];
            d_cnt  <= '0;
        end else begin
            d_cnt <= d_cnt + 1'b1;
        end
    end

    // Transfer sequencer; the single down-counter times both the inhibit
    // period and the gap between device edges. A fall takes priority over
    // the counter reaching zero.
    always_ff @(posedge coreclk) begin
        if (!rst) begin
            state      <= S_IDLE;
            tx_ready   <= 1'b1;
            ps2c_oe    <= 1'b0;
            ps2d_oe    <= 1'b0;
            rx_inhibit <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            cnt        <= '0;
            bitcnt     <= '0;
            shift      <= '0;
`ifdef PS2_TX_RETRY_EN
            retry      <= '0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (tx_valid && tx_ready) begin
                        shift      <= {1'b1, ~^tx_data, tx_data};
                        ps2c_oe    <= 1'b1;
                        rx_inhibit <= 1'b1;
                        tx_ready   <= 1'b0;
                        cnt        <= INHIBIT_LOAD;
`ifdef PS2_TX_RETRY_EN
                        retry      <= '0;
`endif
                        state      <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (cnt == '0) begin
                        ps2d_oe <= 1'b1;
                        state   <= S_RELEASE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_RELEASE: begin
                    ps2c_oe <= 1'b0;
                    cnt     <= TIMEOUT_LOAD;
                    bitcnt  <= '0;
                    state   <= S_SEND;
                end
                S_SEND: begin
                    if (fall) begin
                        ps2d_oe <= ~shift[bitcnt];
                        bitcnt  <= bitcnt + 1'b1;
                        cnt     <= TIMEOUT_LOAD;
                        if (bitcnt == 4'd9) begin
                            state <= S_ACK;
                        end
                    end else if (cnt == '0) begin
                        state <= S_FAIL;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_ACK: begin
                    if (fall) begin
                        if (!d_filt) begin
                            cnt   <= TIMEOUT_LOAD;
                            state <= S_WAITIDLE;
                        end else begin
`ifdef PS2_TX_RETRY_EN
                            if (retry != 2'd2) begin
                                retry   <= retry + 1'b1;
                                ps2c_oe <= 1'b1;
                                ps2d_oe <= 1'b0;
                                cnt     <= INHIBIT_LOAD;
                                state   <= S_INHIBIT;
                            end else begin
                                state <= S_FAIL;
                            end
`else
                            state <= S_FAIL;
`endif
                        end
                    end else if (cnt == '0) begin
                        state <= S_FAIL;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_WAITIDLE: begin
                    if (c_filt && d_filt) begin
                        done       <= 1'b1;
                        rx_inhibit <= 1'b0;
                        tx_ready   <= 1'b1;
                        state      <= S_IDLE;
                    end else if (fall) begin
                        cnt <= TIMEOUT_LOAD;
                    end else if (cnt == '0) begin
                        state <= S_FAIL;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_FAIL: begin
                    ps2c_oe    <= 1'b0;
                    ps2d_oe    <= 1'b0;
                    err        <= 1'b1;
                    rx_inhibit <= 1'b0;
                    tx_ready   <= 1'b1;
                    state      <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: bench for ps2_host_tx with a behavioural PS/2 keyboard on
// an open-drain bus. Requests push expected outcomes into a queue; a monitor
// pops and checks them on every done/err pulse, comparing against the frame
// the keyboard model actually clocked in. Timers are scaled down
// (1 MHz, 100 us inhibit, 1000 us timeout) to keep the run short.
module tb_ps2_host_tx;

    localparam int INH = 100;
    localparam int TO  = 1000;

    logic       coreclk = 1'b0;
    logic       rst = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready;
    logic       ps2c_oe;
    logic       ps2d_oe;
    logic       rx_inhibit;
    logic       done;
    logic       err;

    logic dev_c_low = 1'b0;
    logic dev_d_low = 1'b0;
    logic line_c;
    logic line_d;
    assign line_c = ~(ps2c_oe | dev_c_low);
    assign line_d = ~(ps2d_oe | dev_d_low);

    ps2_host_tx #(
        .CLK_MHZ(1), .INHIBIT_US(INH), .TIMEOUT_US(TO), .DEBOUNCE_CYCLES(4)
    ) dut (
        .coreclk(coreclk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .ps2c_in(line_c), .ps2d_in(line_d),
        .ps2c_oe(ps2c_oe), .ps2d_oe(ps2d_oe), .rx_inhibit(rx_inhibit),
        .done(done), .err(err)
    );

    always #5 coreclk = ~coreclk;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       exp_done;
        logic       frame;
        logic       tmo;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    int vectors = 0;
    int miscompares = 0;

    int         dev_half = 20;
    logic       dev_nack = 1'b0;
    logic       dev_silent = 1'b0;
    logic       dev_busy = 1'b0;
    int         dev_bits = 0;
    logic [9:0] cap_bits = '0;
    logic       cap_start = 1'b1;

    int   cyc = 0;
    int   c_rise = 0;
    int   c_fall = 0;
    logic prev_c_oe = 1'b0;
    logic rst_seen = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        vectors++;
        if (act < lo || act > hi) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return (ones % 2) == 0;
    endfunction

    // Keyboard model: after request-to-send, clocks 10 bits sampled on the
    // rising edge, then acks (data low) or NACKs on the 11th clock.
    initial begin
        logic [9:0] frame;
        int h;
        forever begin
            @(negedge coreclk);
            if (rst && line_c && !line_d && !dev_silent) begin
                dev_busy  = 1'b1;
                dev_bits  = 0;
                cap_start = line_d;
                h = dev_half;
                frame = '0;
                repeat (h) @(negedge coreclk);
                for (int i = 0; i < 10; i++) begin
                    dev_c_low = 1'b1;
                    repeat (h) @(negedge coreclk);
                    dev_c_low = 1'b0;
                    frame[i] = line_d;
                    dev_bits = i + 1;
                    if (i < 9) repeat (h) @(negedge coreclk);
                end
                cap_bits = frame;
                repeat (h / 2) @(negedge coreclk);
                dev_d_low = !dev_nack;
                repeat (h - h / 2) @(negedge coreclk);
                dev_c_low = 1'b1;
                repeat (h) @(negedge coreclk);
                dev_c_low = 1'b0;
                repeat (h / 2) @(negedge coreclk);
                dev_d_low = 1'b0;
                repeat (h - h / 2) @(negedge coreclk);
                dev_busy = 1'b0;
            end
        end
    end

    // Monitor: inhibit length on each clock release, outcome on each pulse.
    initial begin
        forever begin
            @(negedge coreclk);
            cyc++;
            if (!rst) rst_seen = 1'b1;
            if (ps2c_oe && !prev_c_oe) begin
                c_rise = cyc;
                rst_seen = 1'b0;
            end
            if (!ps2c_oe && prev_c_oe) begin
                c_fall = cyc;
                if (!rst_seen && rst) begin
                    check_range("inhibit_len", cyc - c_rise, INH, INH + 3);
                    check("rx_inhibit_busy", 32'(rx_inhibit), 32'd1);
                end
            end
            if (rst && (done || err)) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_pulse: done=%0d err=%0d, expected no pulse", done, err);
                end else begin
                    e = exp_q.pop_front();
                    check("result_done", 32'(done), 32'(e.exp_done));
                    check("result_err", 32'(err), 32'(!e.exp_done));
                    check("lines_released", 32'({ps2c_oe, ps2d_oe}), 32'd0);
                    check("end_ready_inhibit", 32'({tx_ready, rx_inhibit}), 32'b10);
                    if (e.frame) begin
                        check("start_bit", 32'(cap_start), 32'd0);
                        check("data_bits", 32'(cap_bits[7:0]), 32'(e.data));
                        check("parity_bit", 32'(cap_bits[8]), 32'(e.par));
                        check("stop_bit", 32'(cap_bits[9]), 32'd1);
                    end
                    if (e.tmo) check_range("timeout_cycles", cyc - c_fall, TO, TO + 4);
                end
            end
            prev_c_oe = ps2c_oe;
        end
    end

    task automatic issue(input logic [7:0] b, input logic push, input logic exp_done,
                         input logic frame, input logic tmo);
        exp_t r;
        int n = 0;
        while (!tx_ready && n < 2000) begin
            @(negedge coreclk);
            n++;
        end
        if (!tx_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_wait: tx_ready=0 after %0d cycles, expected 1", n);
        end
        r.data = b;
        r.par = odd_parity(b);
        r.exp_done = exp_done;
        r.frame = frame;
        r.tmo = tmo;
        if (push) exp_q.push_back(r);
        tx_valid = 1'b1;
        tx_data = b;
        @(negedge coreclk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_complete();
        int n = 0;
        while ((exp_q.size() != 0 || dev_busy || !tx_ready) && n < 30000) begin
            @(negedge coreclk);
            n++;
        end
        if (n >= 30000) begin
            vectors++;
            miscompares++;
            $display("FAIL completion_wait: %0d outcomes outstanding after %0d cycles, expected 0",
                     exp_q.size(), n);
            exp_q.delete();
        end
        repeat (5) @(negedge coreclk);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_tx_ready"}, 32'(tx_ready), 32'd1);
        check({tag, "_ps2c_oe"}, 32'(ps2c_oe), 32'd0);
        check({tag, "_ps2d_oe"}, 32'(ps2d_oe), 32'd0);
        check({tag, "_rx_inhibit"}, 32'(rx_inhibit), 32'd0);
        check({tag, "_done_err"}, 32'({done, err}), 32'd0);
    endtask

    initial begin
        logic [7:0] b;
        logic nk;
        int n;

        tx_valid = 1'b1;
        tx_data = 8'hED;
        repeat (3) @(negedge coreclk);
        check_idle_outputs("reset");
        tx_valid = 1'b0;
        rst = 1'b1;
        repeat (5) @(negedge coreclk);

        issue(8'hED, 1'b1, 1'b1, 1'b1, 1'b0);
        wait_complete();
        issue(8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
        wait_complete();
        issue(8'h01, 1'b1, 1'b1, 1'b1, 1'b0);
        wait_complete();

        dev_nack = 1'b1;
        issue(8'hA5, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_complete();
        dev_nack = 1'b0;

        dev_silent = 1'b1;
        issue(8'h12, 1'b1, 1'b0, 1'b0, 1'b1);
        wait_complete();
        dev_silent = 1'b0;

        // Edge spacing just under the timeout must not abort.
        dev_half = 450;
        issue(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0);
        wait_complete();
        dev_half = 20;

        // Requests while busy are dropped.
        issue(8'h96, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (10) @(negedge coreclk);
        tx_valid = 1'b1;
        tx_data = 8'h55;
        repeat (30) @(negedge coreclk);
        tx_valid = 1'b0;
        n = 0;
        while (dev_bits < 3 && n < 2000) begin
            @(negedge coreclk);
            n++;
        end
        tx_valid = 1'b1;
        repeat (30) @(negedge coreclk);
        tx_valid = 1'b0;
        wait_complete();

        // Reset in the middle of the data bits.
        issue(8'hC3, 1'b0, 1'b1, 1'b1, 1'b0);
        n = 0;
        while (dev_bits < 4 && n < 2000) begin
            @(negedge coreclk);
            n++;
        end
        check("reached_bit4", 32'(dev_bits >= 4), 32'd1);
        rst = 1'b0;
        tx_valid = 1'b1;
        tx_data = 8'h55;
        @(negedge coreclk);
        check_idle_outputs("midreset");
        @(negedge coreclk);
        tx_valid = 1'b0;
        rst = 1'b1;
        wait_complete();
        issue(8'h5A, 1'b1, 1'b1, 1'b1, 1'b0);
        wait_complete();

        for (int k = 0; k < 12; k++) begin
            b = 8'($urandom);
            nk = ($urandom_range(0, 3) == 0);
            dev_half = int'($urandom_range(15, 30));
            dev_nack = nk;
            issue(b, 1'b1, !nk, 1'b1, 1'b0);
            wait_complete();
        end
        dev_nack = 1'b0;

        repeat (50) @(negedge coreclk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter. It sends one command byte (LED set 0xED, reset 0xFF, typematic 0xF3, and similar) to the keyboard over the same ps2c/ps2d pair the PS/2 scancode receiver listens on. It generates the host request-to-send sequence, shifts out data, parity and stop bits on device-generated clock edges, checks the device ack, and raises rx_inhibit so the receiver ignores the line while a transmission is in progress. It runs in the coreclk (50 MHz) domain; the pads are open-drain, with the top level driving low when an oe output is 1.

Parameters:
CLK_MHZ, 50, coreclk frequency in MHz; scales all timers.
INHIBIT_US, 100, time ps2c is held low before the start bit.
TIMEOUT_US, 15000, maximum wait between device falling edges before abort.
DEBOUNCE_CYCLES, 64, stable samples required before the filtered clock/data change.

Ports:
coreclk  in  1  system clock.
rst  in  1  synchronous, active-low reset.
tx_valid  in  1  request to send tx_data.
tx_data  in  8  command byte.
tx_ready  out  1  block idle; a request is accepted when tx_valid & tx_ready.
ps2c_in  in  1  raw PS/2 clock pad input.
ps2d_in  in  1  raw PS/2 data pad input.
ps2c_oe  out  1  1 = pull ps2c low.
ps2d_oe  out  1  1 = pull ps2d low.
rx_inhibit  out  1  receiver must ignore the bus while high.
done  out  1  one-cycle pulse: byte sent and acked.
err  out  1  one-cycle pulse: NACK or timeout.

Behaviour:
- Reset (rst==0 at posedge coreclk) forces IDLE from any state, including mid-transfer, on that edge.
  - Outputs after reset: tx_ready=1, ps2c_oe=0, ps2d_oe=0, rx_inhibit=0, done=0, err=0.
  - Synchronizers and filters reset to 1.
- Input conditioning:
  - ps2c_in and ps2d_in each pass through a 2-flop synchronizer.
  - Each filtered value updates only after DEBOUNCE_CYCLES consecutive equal samples.
  - fall = filtered clock 1->0 (single-cycle event).
- Counter: one 20-bit down-counter serves both the inhibit and timeout timers. Load values are INHIBIT_US*CLK_MHZ (5000) and TIMEOUT_US*CLK_MHZ (750000).
- All outputs are registered.
- States:
  - IDLE: tx_ready=1. On accept:
    - Latch shift = {1'b1 stop, ~^tx_data odd parity, tx_data}.
    - Set ps2c_oe=1, rx_inhibit=1, tx_ready=0; load the inhibit count; go to INHIBIT.
  - INHIBIT: decrement. At count 0: ps2d_oe=1 (start bit); go to RELEASE.
  - RELEASE: one cycle later, ps2c_oe=0; load the timeout count; bitcnt=0; go to SEND.
  - SEND: on each fall:
    - Drive bit shift[bitcnt] LSB first: ps2d_oe = ~bit.
    - Increment bitcnt and reload the timeout.
    - After the 10th fall (stop bit presented, ps2d_oe=0), go to ACK.
  - ACK: on fall, sample filtered data.
    - 0: ack; go to WAITIDLE.
    - 1: NACK; go to FAIL.
  - WAITIDLE: once filtered clock and data are both 1, pulse done=1 for one cycle, set rx_inhibit=0 and tx_ready=1, go to IDLE.
  - FAIL: ps2c_oe=0, ps2d_oe=0, err=1 for one cycle, rx_inhibit=0; go to IDLE.
- Timeout: in SEND, ACK or WAITIDLE, if the counter reaches 0 go to FAIL. Any fall reloads the counter.
- Handshake and boundary rules:
  - tx_valid while tx_ready=0 is ignored; no queuing.
  - A new request can be accepted the cycle after done/err.
  - A fall in the same cycle as the counter reaching 0 counts as an edge; no timeout occurs.
  - A fall during INHIBIT or RELEASE is ignored.

Optional Feature:
PS2_TX_RETRY_EN
- Defined:
  - A NACK increments a 2-bit retry count and restarts from INHIBIT with the same latched byte, up to 2 retries.
  - err pulses only on the third NACK or on any timeout.
  - The retry count clears on accept.
- Undefined: the first NACK goes straight to FAIL.

Test Plan:
1. Reset: hold rst=0 for 2 cycles with tx_valid=1 and a transfer active -> ps2c_oe=0, ps2d_oe=0, tx_ready=1, rx_inhibit=0, no done/err.
2. Send 0xED; the device model clocks with 40 us half-period and acks low -> ps2c_oe high for 5000 cycles, then start=0. Device samples bits 1,0,1,1,0,1,1,1, parity 1, stop 1. Exactly one done pulse, err=0.
3. Send 0x00 -> data bits all 0 and parity 1. Send 0x01 -> parity 0. Both get done.
4. Device leaves data high on the ack clock -> err pulse and lines released. With PS2_TX_RETRY_EN: 3 full transmissions of the same byte, then err.
5. Device never clocks after RELEASE -> err exactly 750000 cycles after ps2c_oe falls, ps2d_oe=0. With an edge every 20000 cycles, no timeout occurs.
6. tx_valid with 0x55 pulsed while busy -> ignored; only the original byte is sent. Reset asserted after 4 data bits -> lines released on the next edge, and the next request transmits correctly.
